// File: rtl/key_pulse_gen_if.sv
// Key front-end bus: raw button levels in, debounced press reporting out.
// The master side drives the raw pins; the slave side is the debouncer.
interface key_pulse_gen_if #(
    parameter int NUM_KEYS = 4
);
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [NUM_KEYS-1:0] keys_raw;   // raw active-high buttons, asynchronous, bouncing
    logic                keyout;     // one-cycle pulse per accepted press
    logic [KW-1:0]       keycode;    // index of the key reported by the last keyout
    logic [NUM_KEYS-1:0] key_held;   // debounced level of each key

    modport master (
        output keys_raw,
        input  keyout,
        input  keycode,
        input  key_held
    );

    modport slave (
        input  keys_raw,
        output keyout,
        output keycode,
        output key_held
    );
endinterface : key_pulse_gen_if

// File: rtl/key_pulse_gen.sv
// Key pulse generator: per-key 2-FF synchroniser, debounce FSM and press
// edge detection. Emits one registered keyout pulse per clean press together
// with the index of the pressed key; the lowest index wins when several keys
// qualify on the same edge.
module key_pulse_gen #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            nrst,
    key_pulse_gen_if.slave  bus
);

    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    // Lowest set bit of vec wins; scanning downwards lets lower indices overwrite.
    function automatic logic [KW-1:0] lowest_index(input logic [NUM_KEYS-1:0] vec);
        logic [KW-1:0] idx;
        idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (vec[k]) begin
                idx = KW'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Synchroniser stages; only r_sync2 is ever looked at by the FSMs.
    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;

    // Per-key debounce state and qualification counters.
    key_state_e          r_state     [NUM_KEYS];
    key_state_e          w_state_nxt [NUM_KEYS];
    logic [CW-1:0]       r_cnt       [NUM_KEYS];
    logic [CW-1:0]       w_cnt_nxt   [NUM_KEYS];

    logic [NUM_KEYS-1:0] w_press_evt;
    logic [NUM_KEYS-1:0] w_held_nxt;
    logic                w_any_evt;
    logic [KW-1:0]       w_evt_idx;

    // Registered outputs.
    logic                r_keyout;
    logic [KW-1:0]       r_keycode;
    logic [NUM_KEYS-1:0] r_key_held;

    // Two-flop synchroniser bringing the asynchronous pins into the clk domain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.keys_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM state and counter registers for every key.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= ST_RELEASED;
                r_cnt[i]   <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Next-state, counter and press-event decode for every key.
    // A press event fires on the edge that moves PRESS_WAIT into PRESSED, so
    // the registered keyout lines up with the first PRESSED cycle.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_press_evt[i] = 1'b0;

            case (r_state[i])
                ST_RELEASED: begin
                    if (r_sync2[i]) begin
                        w_state_nxt[i] = ST_PRESS_WAIT;
                        w_cnt_nxt[i]   = CNT_ONE;
                    end else begin
                        w_cnt_nxt[i]   = CNT_ZERO;
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!r_sync2[i]) begin
                        // Bounce back to low: abandon this qualification attempt.
                        w_state_nxt[i] = ST_RELEASED;
                        w_cnt_nxt[i]   = CNT_ZERO;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i] = ST_PRESSED;
                        w_cnt_nxt[i]   = CNT_ZERO;
                        w_press_evt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
                    end
                end

                ST_PRESSED: begin
                    if (!r_sync2[i]) begin
                        w_state_nxt[i] = ST_RELEASE_WAIT;
                        w_cnt_nxt[i]   = CNT_ONE;
                    end else begin
                        w_cnt_nxt[i]   = CNT_ZERO;
                    end
                end

                ST_RELEASE_WAIT: begin
                    if (r_sync2[i]) begin
                        // Release glitch: the key is still held, no new event.
                        w_state_nxt[i] = ST_PRESSED;
                        w_cnt_nxt[i]   = CNT_ZERO;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nxt[i] = ST_RELEASED;
                        w_cnt_nxt[i]   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
                    end
                end

                default: begin
                    w_state_nxt[i] = ST_RELEASED;
                    w_cnt_nxt[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    // Debounced level follows the next state so it changes together with the FSM.
    always_comb begin
        w_held_nxt = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if ((w_state_nxt[i] == ST_PRESSED) || (w_state_nxt[i] == ST_RELEASE_WAIT)) begin
                w_held_nxt[i] = 1'b1;
            end else begin
                w_held_nxt[i] = 1'b0;
            end
        end
    end

    // Arbitration of simultaneous press events: lowest index reported, others dropped.
    always_comb begin
        w_any_evt = |w_press_evt;
        w_evt_idx = lowest_index(w_press_evt);
    end

    // Output registers: pulse, held key code and debounced levels.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_keyout   <= 1'b0;
            r_keycode  <= '0;
            r_key_held <= '0;
        end else begin
            r_keyout   <= w_any_evt;
            if (w_any_evt) begin
                r_keycode <= w_evt_idx;
            end else begin
                r_keycode <= r_keycode;
            end
            r_key_held <= w_held_nxt;
        end
    end

    assign bus.keyout   = r_keyout;
    assign bus.keycode  = r_keycode;
    assign bus.key_held = r_key_held;

endmodule : key_pulse_gen
